uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter handshake bundle for uart_tx_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_Req_DV;
    logic [8*NUM_REQ-1:0] i_Req_Byte;
    logic [NUM_REQ-1:0]   o_Req_Ack;
    logic [NUM_REQ-1:0]   o_Req_Done;
    logic                 o_Tx_DV;
    logic [7:0]           o_Tx_Byte;
    logic                 i_Tx_Active;
    logic                 i_Tx_Done;
    logic [2:0]           o_Grant_Idx;
    logic                 o_Busy;

    modport slave (
        input  i_Req_DV, i_Req_Byte, i_Tx_Active, i_Tx_Done,
        output o_Req_Ack, o_Req_Done, o_Tx_DV, o_Tx_Byte, o_Grant_Idx, o_Busy
    );

    modport master (
        output i_Req_DV, i_Req_Byte, i_Tx_Active, i_Tx_Done,
        input  o_Req_Ack, o_Req_Done, o_Tx_DV, o_Tx_Byte, o_Grant_Idx, o_Busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte requesters, one byte per grant.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_L,
    uart_tx_arbiter_if.slave      bus
);
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LAUNCH      = 3'd1,
        WAIT_ACTIVE = 3'd2,
        WAIT_DONE   = 3'd3,
        DRAIN       = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [2:0]         grant_idx;
    logic [7:0]         tx_byte;
    logic [2:0]         win_idx;
    logic               win_vld;
    logic [7:0]         win_byte;
    logic [NUM_REQ-1:0] grant_oh;
    logic               grant_en;

    assign grant_en = (state == IDLE) && win_vld;
    assign grant_oh = NUM_REQ'(1) << grant_idx;

`ifdef UART_ARB_FIXED_PRIO_EN
    // Descending scan: the last hit is the lowest set index.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 3'd0;
        for (int n = NUM_REQ - 1; n >= 0; n--) begin
            if (bus.i_Req_DV[n]) begin
                win_vld = 1'b1;
                win_idx = 3'(n);
            end
        end
    end
`else
    logic [2:0] rr_ptr;

    // Scan from farthest (rr_ptr itself) to nearest (rr_ptr+1) so the nearest set request wins.
    always_comb begin
        int cand;
        cand    = 0;
        win_vld = 1'b0;
        win_idx = 3'd0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (int'(rr_ptr) + k) % NUM_REQ;
            if (bus.i_Req_DV[cand]) begin
                win_vld = 1'b1;
                win_idx = 3'(cand);
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L)
            rr_ptr <= 3'(NUM_REQ - 1);
        else if (grant_en)
            rr_ptr <= win_idx;
    end
`endif

    always_comb begin
        win_byte = 8'h00;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (win_idx == 3'(n))
                win_byte = bus.i_Req_Byte[8*n +: 8];
        end
    end

    // Index and byte are captured at grant, so later requester activity cannot disturb the transfer.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state     <= IDLE;
            grant_idx <= 3'd0;
            tx_byte   <= 8'h00;
        end else begin
            state <= state_nxt;
            if (grant_en) begin
                grant_idx <= win_idx;
                tx_byte   <= win_byte;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.o_Tx_DV    = 1'b0;
        bus.o_Req_Ack  = '0;
        bus.o_Req_Done = '0;
        case (state)
            IDLE: begin
                if (win_vld)
                    state_nxt = LAUNCH;
            end
            LAUNCH: begin
                bus.o_Tx_DV   = 1'b1;
                bus.o_Req_Ack = grant_oh;
                state_nxt     = WAIT_ACTIVE;
            end
            WAIT_ACTIVE: begin
                if (bus.i_Tx_Active)
                    state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.i_Tx_Done) begin
                    bus.o_Req_Done = grant_oh;
                    state_nxt      = DRAIN;
                end
            end
            // Holding here until done falls keeps a long done from double-pulsing or overlapping a launch.
            DRAIN: begin
                if (!bus.i_Tx_Done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.o_Tx_Byte   = tx_byte;
    assign bus.o_Grant_Idx = grant_idx;
    assign bus.o_Busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART transmitter responder.
// Stimulus pushes expected acks/dones; a negedge monitor pops and compares them.
module tb_uart_tx_arbiter;
    localparam int NR = 4;

    logic clk;
    logic rst_n;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NR)) dut (
        .i_Clock (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] b;
    } ack_t;

    ack_t ack_q[$];
    int   done_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh2i(logic [NR-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NR; i++)
            if (v[i]) r = i;
        return r;
    endfunction

    // Behavioural UART transmitter: 1 start, 8 data LSB first, 1 stop; done held tx_done_len cycles.
    int         tx_cpb      = 4;
    int         tx_done_len = 1;
    logic       tx_active, tx_done, tx_serial;
    logic [7:0] tx_sh;
    logic [3:0] tx_bit;
    int         tx_cnt, done_cnt;
    logic       bits_q[$];

    assign bus.i_Tx_Active = tx_active;
    assign bus.i_Tx_Done   = tx_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_active <= 1'b0; tx_done <= 1'b0; tx_serial <= 1'b1;
            tx_sh <= 8'h00; tx_bit <= 4'd0; tx_cnt <= 0; done_cnt <= 0;
        end else if (done_cnt != 0) begin
            done_cnt <= done_cnt - 1;
            if (done_cnt == 1) tx_done <= 1'b0;
        end else if (!tx_active && bus.o_Tx_DV) begin
            tx_sh <= bus.o_Tx_Byte; tx_active <= 1'b1; tx_serial <= 1'b0;
            tx_bit <= 4'd0; tx_cnt <= 0;
        end else if (tx_active) begin
            if (tx_cnt == tx_cpb - 1) begin
                tx_cnt <= 0;
                if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0; tx_done <= 1'b1; done_cnt <= tx_done_len; tx_serial <= 1'b1;
                end else begin
                    tx_bit    <= tx_bit + 4'd1;
                    tx_serial <= (tx_bit == 4'd8) ? 1'b1 : tx_sh[tx_bit[2:0]];
                end
            end else begin
                tx_cnt <= tx_cnt + 1;
            end
        end
    end

    always @(posedge clk)
        if (rst_n && tx_active && tx_cnt == tx_cpb / 2) bits_q.push_back(tx_serial);

    // Monitor / scoreboard
    always @(negedge clk) begin : mon
        ack_t e;
        int   d;
        if (rst_n) begin
            if (bus.o_Req_Ack != '0) begin
                chk("ack_onehot", 32'($onehot(bus.o_Req_Ack)), 32'd1);
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", 32'(bus.o_Req_Ack), 32'd0);
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_idx", oh2i(bus.o_Req_Ack), e.idx);
                    chk("grant_idx", 32'(bus.o_Grant_Idx), e.idx);
                    chk("tx_dv_with_ack", 32'(bus.o_Tx_DV), 32'd1);
                    chk("tx_byte", 32'(bus.o_Tx_Byte), 32'(e.b));
                    chk("dv_while_tx_done", 32'(tx_done), 32'd0);
                end
            end
            if (bus.o_Tx_DV && bus.o_Req_Ack == '0)
                chk("dv_without_ack", 32'(bus.o_Tx_DV), 32'd0);
            if (bus.o_Req_Done != '0) begin
                chk("done_onehot", 32'($onehot(bus.o_Req_Done)), 32'd1);
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'(bus.o_Req_Done), 32'd0);
                end else begin
                    d = done_q.pop_front();
                    chk("done_idx", oh2i(bus.o_Req_Done), d);
                end
            end
        end
    end

    task automatic push(int idx, logic [7:0] b, bit with_done);
        ack_t e;
        e.idx = idx;
        e.b   = b;
        ack_q.push_back(e);
        if (with_done) done_q.push_back(idx);
    endtask

    task automatic wait_acks(string name, int n, int budget);
        int cnt;
        cnt = 0;
        for (int c = 0; c < budget && cnt < n; c++) begin
            @(negedge clk);
            if (bus.o_Req_Ack != '0) cnt++;
        end
        chk(name, cnt, n);
    endtask

    task automatic wait_idle(string name, int budget);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (c < budget && (bus.o_Busy || ack_q.size() != 0 || done_q.size() != 0));
        chk(name, 32'(bus.o_Busy || ack_q.size() != 0 || done_q.size() != 0), 32'd0);
    endtask

    initial begin
        int exp_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        int c;

        rst_n          = 1'b0;
        bus.i_Req_DV   = '0;
        bus.i_Req_Byte = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx_dv",   32'(bus.o_Tx_DV),     32'd0);
        chk("rst_tx_byte", 32'(bus.o_Tx_Byte),   32'd0);
        chk("rst_ack",     32'(bus.o_Req_Ack),   32'd0);
        chk("rst_done",    32'(bus.o_Req_Done),  32'd0);
        chk("rst_busy",    32'(bus.o_Busy),      32'd0);
        chk("rst_grant",   32'(bus.o_Grant_Idx), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(bus.o_Busy), 32'd0);

`ifndef UART_ARB_FIXED_PRIO_EN
        // Round-robin, all four requesting continuously
        bus.i_Req_Byte = {8'h13, 8'h12, 8'h11, 8'h10};
        push(0, 8'h10, 1); push(1, 8'h11, 1); push(2, 8'h12, 1); push(3, 8'h13, 1); push(0, 8'h10, 1);
        bus.i_Req_DV = 4'b1111;
        wait_acks("rr_acks", 5, 400);
        bus.i_Req_DV = '0;
        wait_idle("rr_idle", 400);
`else
        // Fixed priority: req0 and req2 continuously requesting
        bus.i_Req_Byte = {8'h13, 8'h12, 8'h11, 8'h10};
        push(0, 8'h10, 1); push(0, 8'h10, 1); push(0, 8'h10, 1);
        bus.i_Req_DV = 4'b0101;
        wait_acks("fp_acks", 3, 400);
        bus.i_Req_DV = '0;
        wait_idle("fp_idle", 400);
`endif

        // Single request, 48 clocks per bit, serial frame and latency
        tx_cpb = 48;
        bits_q.delete();
        bus.i_Req_Byte[15:8] = 8'hA5;
        push(1, 8'hA5, 1);
        bus.i_Req_DV = 4'b0010;
        #1 chk("dv_before_edge", 32'(bus.o_Tx_DV), 32'd0);
        @(negedge clk);
        chk("latency_dv",   32'(bus.o_Tx_DV),   32'd1);
        chk("latency_byte", 32'(bus.o_Tx_Byte), 32'hA5);
        bus.i_Req_DV         = '0;
        bus.i_Req_Byte[15:8] = 8'hFF;
        wait_idle("single_idle", 1000);
        chk("frame_len", bits_q.size(), 10);
        for (int i = 0; i < 10 && i < bits_q.size(); i++)
            chk($sformatf("serial_bit%0d", i), 32'(bits_q[i]), exp_bits[i]);
        chk("byte_held", 32'(bus.o_Tx_Byte), 32'hA5);
        tx_cpb = 4;

        // Done held two cycles; req2 then req3
        tx_done_len = 2;
        bus.i_Req_Byte = {8'h23, 8'h22, 8'h21, 8'h20};
        push(2, 8'h22, 1); push(3, 8'h23, 1);
        bus.i_Req_DV = 4'b1100;
        wait_acks("ld_ack_a", 1, 200);
        bus.i_Req_DV[2] = 1'b0;
        wait_acks("ld_ack_b", 1, 200);
        bus.i_Req_DV[3] = 1'b0;
        wait_idle("ld_idle", 400);
        tx_done_len = 1;

        // Requester drops right after its request is latched
        bus.i_Req_Byte[7:0] = 8'h5A;
        push(0, 8'h5A, 1);
        bus.i_Req_DV = 4'b0001;
        @(posedge clk);
        #1 bus.i_Req_DV = '0;
        wait_idle("drop_idle", 400);
        repeat (10) @(negedge clk);
        chk("drop_no_regrant", 32'(bus.o_Busy), 32'd0);

        // Reset during data bits aborts the transfer (ack only, no done)
        bus.i_Req_Byte[23:16] = 8'h3C;
        push(2, 8'h3C, 0);
        bus.i_Req_DV = 4'b0100;
        wait_acks("rst_mid_ack", 1, 200);
        bus.i_Req_DV = '0;
        c = 0;
        while (c < 200 && !(tx_active && tx_bit == 4'd4)) begin
            @(negedge clk);
            c++;
        end
        chk("reached_data_bits", 32'(tx_active && tx_bit == 4'd4), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_tx_dv",   32'(bus.o_Tx_DV),     32'd0);
        chk("async_tx_byte", 32'(bus.o_Tx_Byte),   32'd0);
        chk("async_ack",     32'(bus.o_Req_Ack),   32'd0);
        chk("async_done",    32'(bus.o_Req_Done),  32'd0);
        chk("async_busy",    32'(bus.o_Busy),      32'd0);
        chk("async_grant",   32'(bus.o_Grant_Idx), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.i_Req_Byte[31:24] = 8'hC3;
        push(3, 8'hC3, 1);
        bus.i_Req_DV = 4'b1000;
        @(negedge clk);
        chk("post_rst_dv",    32'(bus.o_Tx_DV),     32'd1);
        chk("post_rst_grant", 32'(bus.o_Grant_Idx), 32'd3);
        bus.i_Req_DV = '0;
        wait_idle("post_rst_idle", 400);

        chk("ack_q_empty",  ack_q.size(),  0);
        chk("done_q_empty", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
